// File: rtl/seq_divider16_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Holds the FSM encoding, the default operand width and the step-counter width.
package seq_div_pkg;

    localparam int DIV_WIDTH = 16;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider16_if.sv
// Start/done request bus between a client and the sequential divider.
// Client drives the operands and start; the divider returns status and results.
interface seq_divider16_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider16_cla_sub.sv
// Combinational a + ~b + 1 built from 4-bit carry-lookahead groups rippled together.
// Zero latency; cout = 1 means no borrow (a >= b).
module cla_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         cout_o
);

    localparam int G  = (N + 3) / 4;
    localparam int W4 = 4 * G;

    // Padding bits beyond N have g = p = 0, so a partial top group still resolves correctly
    logic [W4-1:0] g_w;
    logic [W4-1:0] p_w;
    logic [N:0]    c_w;

    assign g_w = W4'(a_i & ~b_i);
    assign p_w = W4'(a_i ^ ~b_i);

    always_comb begin
        logic       carry;
        logic [3:0] gg;
        logic [3:0] pp;
        logic [4:0] k;
        c_w   = '0;
        carry = 1'b1;
        gg    = '0;
        pp    = '0;
        k     = '0;
        for (int grp = 0; grp < G; grp++) begin
            gg   = g_w[4*grp +: 4];
            pp   = p_w[4*grp +: 4];
            k[0] = carry;
            k[1] = gg[0] | (pp[0] & k[0]);
            k[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & k[0]);
            k[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & k[0]);
            k[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & k[0]);
            for (int b = 0; b < 5; b++) begin
                if (4*grp + b <= N) begin
                    c_w[4*grp + b] = k[b];
                end
            end
            carry = k[4];
        end
    end

    assign diff_o = p_w[N-1:0] ^ c_w[N-1:0];
    assign cout_o = c_w[N];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency WIDTH+1 edges (1 for divide-by-zero); start ignored while busy, no queueing.
module seq_divider16
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider16_if.slave  div_if
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   t_d;
    logic [WIDTH:0]   diff_d;
    logic             cout_d;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    cla_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .a_i    (t_d),
        .b_i    ({1'b0, d_q}),
        .diff_o (diff_d),
        .cout_o (cout_d)
    );

    // One restoring step: shift the next dividend bit into R, keep the difference if no borrow
    always_comb begin
        t_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_d = t_d;
        q_d = {q_q[WIDTH-2:0], 1'b0};
        if (cout_d) begin
            r_d = diff_d;
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_if.start) begin
                        q_q   <= div_if.dividend;
                        d_q   <= div_if.divisor;
                        r_q   <= '0;
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                        if (div_if.divisor == '0) begin
                            state_q <= DONE;
                            quot_q  <= '1;
                            rem_q   <= div_if.dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        quot_q  <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // R stays below D, so its top bit is only needed as headroom for the subtractor
    a_r_bound: assert property (@(posedge clk) disable iff (!rst_n) (r_q[WIDTH] == 1'b0));

    assign div_if.busy        = (state_q != IDLE);
    assign div_if.done        = (state_q == DONE);
    assign div_if.quotient    = quot_q;
    assign div_if.remainder   = rem_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases plus random operands vs. plain a/b, a%b.
module tb_seq_divider16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_divider16_if #(.WIDTH(16)) dif ();

    seq_divider16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with the divider idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_at);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          k;
        if (b == 16'd0) begin
            eq = 16'hFFFF;
            er = a;
            ez = 1'b1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        k            = 1;
        dif.start    = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 16'($urandom);
        while (dif.done !== 1'b1 && k <= 40) begin
            chk("busy_run", 32'(dif.busy), 32'd1);
            if (k == pulse_at) begin
                dif.start    = 1'b1;
                dif.dividend = 16'd50;
                dif.divisor  = 16'd5;
            end
            @(negedge clk);
            dif.start = 1'b0;
            k++;
        end
        if (k > 40) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(k), (b == 16'd0) ? 32'd1 : 32'd17);
        chk("quotient", 32'(dif.quotient), 32'(eq));
        chk("remainder", 32'(dif.remainder), 32'(er));
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(ez));
        chk("busy_at_done", 32'(dif.busy), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(dif.done), 32'd0);
        chk("busy_after", 32'(dif.busy), 32'd0);
        chk("q_hold", 32'(dif.quotient), 32'(eq));
        chk("r_hold", 32'(dif.remainder), 32'(er));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(dif.busy), 32'd0);
        chk({tag, "_done"}, 32'(dif.done), 32'd0);
        chk({tag, "_quot"}, 32'(dif.quotient), 32'd0);
        chk({tag, "_rem"}, 32'(dif.remainder), 32'd0);
        chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1);
    end

    initial begin
        logic        extra_done;
        logic [15:0] ra;
        logic [15:0] rb;

        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd100, 16'd7, 0);
        run_op(16'hFFFF, 16'd1, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'd3, 16'd10, 0);
        run_op(16'h8000, 16'h8001, 0);
        run_op(16'd5, 16'd0, 0);
        run_op(16'd9, 16'd3, 0);

        // A start pulse mid-run must neither disturb the result nor spawn a second operation
        run_op(16'd1000, 16'd9, 6);
        extra_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dif.done === 1'b1 || dif.busy === 1'b1) extra_done = 1'b1;
        end
        chk("extra_done", 32'(extra_done), 32'd0);

        // Reset dropped at iteration 8 aborts with no done pulse
        dif.start    = 1'b1;
        dif.dividend = 16'd40000;
        dif.divisor  = 16'd123;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_abort_busy", 32'(dif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        chk("abort_no_done", 32'(dif.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(dif.done), 32'd0);
        run_op(16'd40000, 16'd123, 0);

        for (int i = 0; i < 2500; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                2:       rb = ra;
                3:       rb = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 31));
            run_op(ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
